// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle 32-bit shifter (SLL/SRL/SRA/ROTR).
// Moves at most STEP bit positions per cycle and completes through a
// start/busy/done handshake. STEP must be 1, 2, 4, 8 or 16.
module iter_shift_unit #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [4:0]  sdist,
    input  logic [1:0]  sf,
    output logic        busy,
    output logic        done,
    output logic [31:0] sres
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [4:0] STEPV = 5'(STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  func_q, func_d;
    logic [31:0] sres_q, sres_d;

    logic [4:0]  n;
    logic [31:0] shifted;

    // Shift w by n (n <= STEP) using only the power-of-two stages that
    // STEP can need; each stage applies the same function, so SRA keeps
    // replicating the invariant sign bit and ROTR composes.
    function automatic logic [31:0] step_shift(input logic [31:0] w,
                                               input logic [4:0]  amt,
                                               input logic [1:0]  f);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 5; i++) begin
            if (((32'd1 << i) <= STEP) && amt[i]) begin
                case (f)
                    2'b00:   r = r << (1 << i);
                    2'b01:   r = r >> (1 << i);
                    2'b11:   r = $unsigned($signed(r) >>> (1 << i));
                    default: r = (r >> (1 << i)) | (r << (32 - (1 << i)));
                endcase
            end
        end
        return r;
    endfunction

    // Per-cycle shift amount and the shifted working value.
    always_comb begin
        n       = (rem_q < STEPV) ? rem_q : STEPV;
        shifted = step_shift(work_q, n, func_q);
    end

    // Next-state logic: capture in IDLE/DONE, iterate in SHIFT.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        func_d  = func_q;
        sres_d  = sres_q;
        case (state_q)
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - n;
                if (rem_q == n) begin
                    sres_d  = shifted;
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation.
                if (start) begin
                    work_d = a;
                    rem_d  = sdist;
                    func_d = sf;
                    if (sdist == 5'd0) begin
                        sres_d  = a;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= 32'd0;
            rem_q   <= 5'd0;
            func_q  <= 2'b00;
            sres_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            func_q  <= func_d;
            sres_q  <= sres_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        sres = sres_q;
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: one STEP=1 and one STEP=4 instance.
module tb_iter_shift_unit;

    logic        clk;
    logic        reset;
    logic        start1, start4;
    logic [31:0] a;
    logic [4:0]  sdist;
    logic [1:0]  sf;
    logic        busy1, done1, busy4, done4;
    logic [31:0] sres1, sres4;

    int n_tests = 0;
    int n_fail  = 0;

    iter_shift_unit #(.STEP(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .a     (a),
        .sdist (sdist),
        .sf    (sf),
        .busy  (busy1),
        .done  (done1),
        .sres  (sres1)
    );

    iter_shift_unit #(.STEP(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .a     (a),
        .sdist (sdist),
        .sf    (sf),
        .busy  (busy4),
        .done  (done4),
        .sres  (sres4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation on the selected instance; lat is the cycle index
    // (T+lat) of the done pulse, 0 if none within the budget.
    task automatic do_op(input int sel, input logic [31:0] av, input logic [4:0] dv,
                         input logic [1:0] fv, output int lat, output logic [31:0] res,
                         output int nbusy);
        @(negedge clk);
        a = av; sdist = dv; sf = fv;
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        lat = 0; res = 32'd0; nbusy = 0;
        for (int c = 1; c <= 64; c++) begin
            if ((sel == 1) ? done1 : done4) begin
                lat = c;
                res = (sel == 1) ? sres1 : sres4;
                break;
            end
            if ((sel == 1) ? busy1 : busy4) nbusy++;
            @(negedge clk);
        end
    endtask

    int          lat, nbusy, ndone, first;
    logic [31:0] res, res_a, res_b;

    initial begin
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = 32'd0; sdist = 5'd0; sf = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_sres1", sres1, 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_sres4", sres4, 32'd0);
        reset = 1'b0;

        // STEP=1 basic functions
        do_op(1, 32'h0000_0001, 5'd2, 2'b00, lat, res, nbusy);
        check("sll1_res", res, 32'h0000_0004);
        check("sll1_lat", lat, 3);
        check("sll1_busy", nbusy, 2);
        do_op(1, 32'h0000_0010, 5'd3, 2'b01, lat, res, nbusy);
        check("srl1_res", res, 32'h0000_0002);
        check("srl1_lat", lat, 4);
        do_op(1, 32'hFFFF_FFE0, 5'd3, 2'b11, lat, res, nbusy);
        check("sra1_res", res, 32'hFFFF_FFFC);
        do_op(1, 32'h0000_0001, 5'd1, 2'b10, lat, res, nbusy);
        check("rotr1_res", res, 32'h8000_0000);

        // STEP=4 functions and edge distances
        do_op(4, 32'h8000_0001, 5'd31, 2'b10, lat, res, nbusy);
        check("rotr4_res", res, 32'h0000_0003);
        check("rotr4_lat", lat, 9);
        check("rotr4_busy", nbusy, 8);
        do_op(4, 32'h1234_5678, 5'd0, 2'b11, lat, res, nbusy);
        check("zero4_res", res, 32'h1234_5678);
        check("zero4_lat", lat, 1);
        check("zero4_busy", nbusy, 0);
        do_op(4, 32'h8000_0000, 5'd5, 2'b11, lat, res, nbusy);
        check("sra4_res", res, 32'hFC00_0000);
        check("sra4_lat", lat, 3);
        do_op(4, 32'h0000_0001, 5'd7, 2'b00, lat, res, nbusy);
        check("sll4_res", res, 32'h0000_0080);
        do_op(4, 32'hF000_0000, 5'd16, 2'b01, lat, res, nbusy);
        check("srl4_res", res, 32'h0000_F000);
        check("srl4_lat", lat, 5);

        // Start while busy must be ignored
        @(negedge clk);
        a = 32'h0000_FFFF; sdist = 5'd8; sf = 2'b00; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        ndone = 0; first = 0; res = 32'd0;
        for (int c = 1; c <= 14; c++) begin
            if (done1) begin
                ndone++;
                if (first == 0) begin first = c; res = sres1; end
            end
            if (c == 3) begin a = 32'hFFFF_FFFF; start1 = 1'b1; end
            if (c == 4) start1 = 1'b0;
            @(negedge clk);
        end
        check("ign_res", res, 32'h00FF_FF00);
        check("ign_ndone", ndone, 1);
        check("ign_lat", first, 9);

        // Back-to-back: start held through the first done
        @(negedge clk);
        a = 32'h0000_0001; sdist = 5'd2; sf = 2'b00; start1 = 1'b1;
        @(negedge clk);
        a = 32'h8000_0000; sdist = 5'd1; sf = 2'b11;
        ndone = 0; first = 0; res_a = 32'd0; res_b = 32'd0; nbusy = 0;
        for (int c = 1; c <= 10; c++) begin
            if (done1) begin
                ndone++;
                if (ndone == 1) begin first = c; res_a = sres1; end
                else res_b = sres1;
                if (ndone == 2) check("b2b_gap", c - first, 2);
            end
            if (c == 4) begin
                nbusy = int'(busy1);
                start1 = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_first", first, 3);
        check("b2b_res1", res_a, 32'h0000_0004);
        check("b2b_res2", res_b, 32'hC000_0000);
        check("b2b_nobubble", nbusy, 1);
        check("b2b_ndone", ndone, 2);

        // Reset mid-operation
        @(negedge clk);
        a = 32'h0000_0001; sdist = 5'd20; sf = 2'b00; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy1), 32'd0);
        check("rst_mid_done", 32'(done1), 32'd0);
        check("rst_mid_sres", sres1, 32'd0);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (done1) ndone++;
            @(negedge clk);
        end
        check("rst_mid_nodone", ndone, 0);
        do_op(1, 32'h0000_0003, 5'd4, 2'b00, lat, res, nbusy);
        check("post_rst_res", res, 32'h0000_0030);
        check("post_rst_lat", lat, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Multi-cycle shifter for the MIPS datapath. It accepts the same operand, distance and function encoding as the combinational shift unit, and produces the result over several cycles using a start/busy/done handshake. It sits beside the ALU in the execute stage. The controller stalls on `busy` and latches `sres` on `done`. It exists for area-reduced builds where a full 32-bit barrel shifter is too costly.

## Interface
- `STEP`, default 1: maximum bit positions shifted per cycle. Legal values are 1, 2, 4, 8, 16.
- `clk`: input, 1 bit, rising-edge clock.
- `reset`: input, 1 bit, synchronous, active-high.
- `start`: input, 1 bit, request to begin a shift. Sampled only when `busy`=0.
- `a`: input, 32 bits, operand. Sampled with an accepted `start`.
- `sdist`: input, 5 bits, shift distance 0..31. Sampled with an accepted `start`.
- `sf`: input, 2 bits, function. 00 SLL, 01 SRL, 11 SRA, 10 ROTR (rotate right). Sampled with an accepted `start`.
- `busy`: output, 1 bit, high while an operation is in progress.
- `done`: output, 1 bit, one-cycle pulse when `sres` has just been updated.
- `sres`: output, 32 bits, registered result. Holds its value until the next completion.

## Operation
- State machine: IDLE → SHIFT → DONE.
  - IDLE, or DONE with `start`=1: capture `a` into `work`, `sdist` into `rem`, and `sf` into `func`.
    - If `sdist`≠0: go to SHIFT.
    - If `sdist`=0: go straight to DONE and load `sres`=`a`.
  - SHIFT: each cycle, let n = min(`STEP`, `rem`). Shift `work` by n according to `func`, then `rem` -= n.
    - When the new `rem` is 0: load `sres` with the shifted value and go to DONE.
  - DONE: lasts exactly one cycle. Go to IDLE, or capture a new operation if `start`=1.
- Per-step function:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill from the MSB with `func`-captured bit 31 of the original operand, i.e. the current `work[31]`, which stays invariant.
  - ROTR: bits leaving the LSB re-enter at the MSB.
- The final result must equal the single-step result for the same `a`, `sdist` and `sf` for every STEP value.
- `busy` = (state==SHIFT).
- `done` = (state==DONE).
- `start` while `busy`=1 is ignored. Captured operands are unaffected.
- Input changes after capture have no effect on the operation in flight.
- Reset values: state IDLE, `busy` 0, `done` 0, `sres` 0, `work` 0, `rem` 0, `func` 00.
- Reset mid-operation: the operation is aborted, no `done` pulse is produced, and `sres` returns to 0.

## Timing
- Latency: `start` is sampled high at the edge ending cycle T. Then `done`=1 during cycle T+1+ceil(`sdist`/`STEP`).
  - `sdist`=0 gives `done` in T+1.
- `busy` is high from T+1 through the last SHIFT cycle. It is low in the DONE cycle.
- `sres` changes only on the edge that enters DONE, or on reset.
- Back-to-back operation: `start` held high during the DONE cycle is accepted.
  - The next operation's `busy` or `done` follows with no idle bubble.
  - In the worst case, throughput is one result per ceil(`sdist`/`STEP`)+1 cycles.
- `done` never asserts in two consecutive cycles unless the second operation has `sdist`=0.

## Test plan
- STEP=1, SLL: `a`=0x00000001, `sdist`=2, `sf`=00, start at T → `busy` high in T+1..T+2, `done` in T+3, `sres`=0x00000004.
- STEP=1, SRL then SRA: `a`=0x00000010, `sdist`=3, `sf`=01 → `sres`=0x00000002, `done` in T+4.
  - Next: `a`=0xFFFFFFE0, `sdist`=3, `sf`=11 → `sres`=0xFFFFFFFC.
- STEP=4, ROTR and edge distance: `a`=0x80000001, `sdist`=31, `sf`=10 → `sres`=0x00000003, `done` in T+9.
  - Also: `sdist`=0, `sf`=11 → `sres`=`a`, `done` in T+1, `busy` never high.
- Ignored start: begin `a`=0x0000FFFF, `sdist`=8, `sf`=00.
  - At T+3, pulse `start` with `a`=0xFFFFFFFF → `sres`=0x00FFFF00 and exactly one `done` pulse.
- Back-to-back: hold `start` high through `done`. Second operation `a`=0x80000000, `sdist`=1, `sf`=11 → `sres`=0xC0000000, `done` 2 cycles after the first `done`.
- Reset mid-operation: start `sdist`=20, assert `reset` at T+5 for 1 cycle → `busy`=0, `done`=0, `sres`=0 after the reset edge.
  - No `done` for the aborted operation.
  - A new start then completes normally.
